// File: rtl/stat_pkg.sv
// Shared definitions for the statistics-engine sample feeder: data widths and
// the launch FSM encoding.
package stat_pkg;
   localparam int DATA_W = 32;
   localparam int WCNT_W = 16;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_BUSY   = 2'd2
   } state_e;
endpackage

// File: rtl/stat_sample_ram.sv
// Circular sample storage: synchronous write, asynchronous read so the engine
// sees the sample in the same cycle it presents an index.
module stat_sample_ram
   import stat_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              Clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge Clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/stat_window_feeder.sv
// Buffers incoming samples, launches the stats engine on each full window,
// serves its index->value reads and slides the window by HOP on completion.
module stat_window_feeder
   import stat_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIN   = 8,
   parameter int HOP   = 8
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic [DATA_W-1:0] index,
   output logic [DATA_W-1:0] value,
   output logic [DATA_W-1:0] si,
   output logic [DATA_W-1:0] ei,
   output logic              start,
   input  logic              done,
   input  logic [DATA_W-1:0] mean_in,
   input  logic [DATA_W-1:0] variance_in,
   output logic              res_valid,
   output logic [DATA_W-1:0] res_mean,
   output logic [DATA_W-1:0] res_variance,
   output logic [WCNT_W-1:0] win_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0]   WIN_C   = (AW+1)'(WIN);
   localparam logic [AW:0]   HOP_OCC = (AW+1)'(HOP);
   localparam logic [AW-1:0] HOP_PTR = AW'(HOP);

   state_e              state_q, state_d;
   logic [AW-1:0]       wp_q, wp_d, base_q, base_d;
   logic [AW:0]         occ_q, occ_d;
   logic                res_valid_q, res_valid_d;
   logic [DATA_W-1:0]   res_mean_q, res_mean_d, res_var_q, res_var_d;
   logic [WCNT_W-1:0]   win_count_q, win_count_d;

   logic                busy, can_accept, wr_en, done_ok;
   logic [AW-1:0]       rd_addr;
   logic [DATA_W-1:0]   rd_data;

   // FSM: state register
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state_q <= ST_FILL;
      else      state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FILL:   if (occ_q >= WIN_C) state_d = ST_LAUNCH;
         ST_LAUNCH: state_d = ST_BUSY;
         ST_BUSY:   if (done) state_d = ST_FILL;
         default:   state_d = ST_FILL;
      endcase
   end

   // FSM: outputs
   always_comb begin
      start = 1'b0;
      busy  = 1'b0;
      case (state_q)
         ST_LAUNCH: start = 1'b1;
         ST_BUSY:   busy  = 1'b1;
         default:   ;
      endcase
   end

   always_comb begin
      can_accept  = (occ_q < DEPTH_C);
      wr_en       = in_valid && can_accept;
      done_ok     = done && busy;
      wp_d        = wr_en ? wp_q + AW'(1) : wp_q;
      // A write and a completion in the same cycle net out to +1-HOP.
      occ_d       = occ_q + (AW+1)'(wr_en) - (done_ok ? HOP_OCC : '0);
      base_d      = done_ok ? base_q + HOP_PTR : base_q;
      res_valid_d = done_ok;
      res_mean_d  = done_ok ? mean_in : res_mean_q;
      res_var_d   = done_ok ? variance_in : res_var_q;
      win_count_d = done_ok ? win_count_q + WCNT_W'(1) : win_count_q;
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         wp_q        <= '0;
         base_q      <= '0;
         occ_q       <= '0;
         res_valid_q <= 1'b0;
         res_mean_q  <= '0;
         res_var_q   <= '0;
         win_count_q <= '0;
      end else begin
         wp_q        <= wp_d;
         base_q      <= base_d;
         occ_q       <= occ_d;
         res_valid_q <= res_valid_d;
         res_mean_q  <= res_mean_d;
         res_var_q   <= res_var_d;
         win_count_q <= win_count_d;
      end
   end

   stat_sample_ram #(.DEPTH(DEPTH)) u_ram (
      .Clk   (Clk),
      .we    (wr_en),
      .waddr (wp_q),
      .wdata (in_data),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   assign rd_addr = base_q + index[AW-1:0];
   assign value   = (busy && (index < DATA_W'(WIN))) ? rd_data : '0;

   // Combinational outputs are held at 0 while reset is asserted.
   assign in_ready     = Rst && can_accept;
   assign si           = '0;
   assign ei           = Rst ? DATA_W'(WIN) : '0;
   assign res_valid    = res_valid_q;
   assign res_mean     = res_mean_q;
   assign res_variance = res_var_q;
   assign win_count    = win_count_q;
endmodule

// File: tb/tb_stat_window_feeder.sv
// Directed bench for stat_window_feeder: DEPTH=8/WIN=4 with HOP=4 (dut) and HOP=2 (dut2).
module tb_stat_window_feeder;
   logic        Clk = 1'b0;
   logic        Rst;
   logic        in_valid, in_ready, start, done, res_valid;
   logic [31:0] in_data, index, value, si, ei, mean_in, variance_in, res_mean, res_variance;
   logic [15:0] win_count;

   logic        v2, in_ready2, start2, done2, res_valid2;
   logic [31:0] d2, idx2, value2, si2, ei2, mean2, var2, res_mean2, res_var2;
   logic [15:0] win_count2;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   stat_window_feeder #(.DEPTH(8), .WIN(4), .HOP(4)) dut (
      .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .index(index), .value(value), .si(si), .ei(ei), .start(start), .done(done),
      .mean_in(mean_in), .variance_in(variance_in), .res_valid(res_valid),
      .res_mean(res_mean), .res_variance(res_variance), .win_count(win_count)
   );

   stat_window_feeder #(.DEPTH(8), .WIN(4), .HOP(2)) dut2 (
      .Clk(Clk), .Rst(Rst), .in_valid(v2), .in_data(d2), .in_ready(in_ready2),
      .index(idx2), .value(value2), .si(si2), .ei(ei2), .start(start2), .done(done2),
      .mean_in(mean2), .variance_in(var2), .res_valid(res_valid2),
      .res_mean(res_mean2), .res_variance(res_var2), .win_count(win_count2)
   );

   task automatic step();
      @(posedge Clk); #1;
   endtask

   task automatic push(input logic [31:0] v);
      in_valid = 1'b1; in_data = v;
      step();
      in_valid = 1'b0;
   endtask

   task automatic push2(input logic [31:0] v);
      v2 = 1'b1; d2 = v;
      step();
      v2 = 1'b0;
   endtask

   task automatic do_reset();
      Rst = 1'b0;
      in_valid = 0; done = 0; index = 0; v2 = 0; done2 = 0; idx2 = 0;
      repeat (2) step();
      Rst = 1'b1;
      step();
   endtask

   task automatic test_reset();
      Rst = 1'b0;
      in_valid = 0; in_data = 0; index = 0; done = 0; mean_in = 0; variance_in = 0;
      v2 = 0; d2 = 0; idx2 = 0; done2 = 0; mean2 = 0; var2 = 0;
      #3;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0d exp 0", in_ready); end
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL rst_start got %0d exp 0", start); end
      checks++; if (ei !== 32'd0) begin errors++; $display("FAIL rst_ei got %0d exp 0", ei); end
      checks++; if (res_valid !== 1'b0 || res_mean !== 32'd0 || win_count !== 16'd0)
         begin errors++; $display("FAIL rst_results got v=%0d m=%0d wc=%0d exp 0", res_valid, res_mean, win_count); end
      step(); step();
      Rst = 1'b1;
      @(negedge Clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %0d exp 1", in_ready); end
      checks++; if (si !== 32'd0 || ei !== 32'd4) begin errors++; $display("FAIL post_rst_si_ei got %0d/%0d exp 0/4", si, ei); end
      checks++; if (dut.occ_q !== 4'd0) begin errors++; $display("FAIL post_rst_occ got %0d exp 0", dut.occ_q); end
   endtask

   task automatic test_fill_launch();
      push(2); push(4); push(6); push(8);
      @(negedge Clk);
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL fill_start_early got %0d exp 0", start); end
      step();
      checks++; if (start !== 1'b1) begin errors++; $display("FAIL fill_start got %0d exp 1", start); end
      checks++; if (si !== 32'd0 || ei !== 32'd4) begin errors++; $display("FAIL fill_si_ei got %0d/%0d exp 0/4", si, ei); end
      step();
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL fill_start_pulse got %0d exp 0", start); end
      index = 0; #1;
      checks++; if (value !== 32'd2) begin errors++; $display("FAIL fill_idx0 got %0d exp 2", value); end
      index = 3; #1;
      checks++; if (value !== 32'd8) begin errors++; $display("FAIL fill_idx3 got %0d exp 8", value); end
      index = 4; #1;
      checks++; if (value !== 32'd0) begin errors++; $display("FAIL fill_idx4 got %0d exp 0", value); end
      index = 1; #1;
      checks++; if (value !== 32'd4) begin errors++; $display("FAIL fill_idx1 got %0d exp 4", value); end
   endtask

   task automatic test_result();
      done = 1'b1; mean_in = 5; variance_in = 2;
      step();
      done = 1'b0;
      @(negedge Clk);
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL res_valid got %0d exp 1", res_valid); end
      checks++; if (res_mean !== 32'd5 || res_variance !== 32'd2)
         begin errors++; $display("FAIL res_vals got %0d/%0d exp 5/2", res_mean, res_variance); end
      checks++; if (win_count !== 16'd1) begin errors++; $display("FAIL res_wc got %0d exp 1", win_count); end
      checks++; if (dut.occ_q !== 4'd0) begin errors++; $display("FAIL res_occ got %0d exp 0", dut.occ_q); end
      index = 0; #1;
      checks++; if (value !== 32'd0) begin errors++; $display("FAIL res_fill_value got %0d exp 0", value); end
      step();
      @(negedge Clk);
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL res_pulse got %0d exp 0", res_valid); end
   endtask

   task automatic test_backpressure();
      for (int k = 10; k < 18; k++) push(k);
      in_valid = 1'b1; in_data = 18;
      step();
      @(negedge Clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0d exp 0", in_ready); end
      checks++; if (dut.occ_q !== 4'd8) begin errors++; $display("FAIL bp_occ got %0d exp 8", dut.occ_q); end
      index = 0; #1;
      checks++; if (value !== 32'd10) begin errors++; $display("FAIL bp_idx0 got %0d exp 10", value); end
      index = 3; #1;
      checks++; if (value !== 32'd13) begin errors++; $display("FAIL bp_idx3 got %0d exp 13", value); end
      done = 1'b1; mean_in = 7; variance_in = 3;
      @(posedge Clk); #1;
      done = 1'b0; in_valid = 1'b0;
      @(negedge Clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %0d exp 1", in_ready); end
      checks++; if (dut.occ_q !== 4'd4) begin errors++; $display("FAIL bp_occ_after got %0d exp 4", dut.occ_q); end
      checks++; if (win_count !== 16'd2 || res_mean !== 32'd7)
         begin errors++; $display("FAIL bp_result got wc=%0d m=%0d exp 2/7", win_count, res_mean); end
      step();
      checks++; if (start !== 1'b1) begin errors++; $display("FAIL bp_second_start got %0d exp 1", start); end
      step();
      index = 0; #1;
      checks++; if (value !== 32'd14) begin errors++; $display("FAIL bp_w2_idx0 got %0d exp 14", value); end
      index = 3; #1;
      checks++; if (value !== 32'd17) begin errors++; $display("FAIL bp_w2_idx3 got %0d exp 17", value); end
      done = 1'b1;
      step();
      done = 1'b0;
   endtask

   task automatic test_simultaneous();
      do_reset();
      for (int k = 1; k <= 6; k++) push2(k);
      checks++; if (dut2.occ_q !== 4'd6 || start2 !== 1'b0)
         begin errors++; $display("FAIL sim_pre got occ=%0d start=%0d exp 6/0", dut2.occ_q, start2); end
      v2 = 1'b1; d2 = 7; done2 = 1'b1; mean2 = 11; var2 = 1;
      step();
      v2 = 1'b0; done2 = 1'b0;
      @(negedge Clk);
      checks++; if (dut2.occ_q !== 4'd5) begin errors++; $display("FAIL sim_occ got %0d exp 5", dut2.occ_q); end
      checks++; if (dut2.base_q !== 3'd2) begin errors++; $display("FAIL sim_base got %0d exp 2", dut2.base_q); end
      checks++; if (res_valid2 !== 1'b1 || res_mean2 !== 32'd11 || win_count2 !== 16'd1)
         begin errors++; $display("FAIL sim_result got v=%0d m=%0d wc=%0d exp 1/11/1", res_valid2, res_mean2, win_count2); end
      step(); step();
      idx2 = 0; #1;
      checks++; if (value2 !== 32'd3) begin errors++; $display("FAIL sim_idx0 got %0d exp 3", value2); end
      idx2 = 3; #1;
      checks++; if (value2 !== 32'd6) begin errors++; $display("FAIL sim_idx3 got %0d exp 6", value2); end
      idx2 = 4; #1;
      checks++; if (value2 !== 32'd0) begin errors++; $display("FAIL sim_idx4 got %0d exp 0", value2); end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int w = 0; w < 3; w++) begin
         for (int k = 1; k <= 4; k++) push(32'(4*w + k));
         step(); step();
         if (w == 2) begin
            checks++; if (dut.base_q !== 3'd0) begin errors++; $display("FAIL wrap_base got %0d exp 0", dut.base_q); end
         end
         index = 0; #1;
         checks++; if (value !== 32'(4*w + 1)) begin errors++; $display("FAIL wrap_idx0 w%0d got %0d exp %0d", w, value, 4*w + 1); end
         index = 3; #1;
         checks++; if (value !== 32'(4*w + 4)) begin errors++; $display("FAIL wrap_idx3 w%0d got %0d exp %0d", w, value, 4*w + 4); end
         done = 1'b1; mean_in = 32'(100 + w);
         step();
         done = 1'b0;
         @(negedge Clk);
         checks++; if (win_count !== 16'(w + 1) || res_mean !== 32'(100 + w))
            begin errors++; $display("FAIL wrap_result w%0d got wc=%0d m=%0d exp %0d/%0d", w, win_count, res_mean, w + 1, 100 + w); end
      end
   endtask

   task automatic test_reset_mid_busy();
      for (int k = 30; k < 34; k++) push(k);
      step();
      checks++; if (start !== 1'b1) begin errors++; $display("FAIL rmb_launch got %0d exp 1", start); end
      step();
      index = 0;
      Rst = 1'b0; #1;
      checks++; if (start !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b0)
         begin errors++; $display("FAIL rmb_drop got st=%0d rv=%0d rdy=%0d exp 0/0/0", start, res_valid, in_ready); end
      checks++; if (win_count !== 16'd0 || value !== 32'd0)
         begin errors++; $display("FAIL rmb_clear got wc=%0d val=%0d exp 0/0", win_count, value); end
      #2; Rst = 1'b1;
      step();
      checks++; if (dut.occ_q !== 4'd0) begin errors++; $display("FAIL rmb_occ got %0d exp 0", dut.occ_q); end
      done = 1'b1; mean_in = 99;
      step();
      done = 1'b0;
      @(negedge Clk);
      checks++; if (res_valid !== 1'b0 || res_mean !== 32'd0 || win_count !== 16'd0 || start !== 1'b0)
         begin errors++; $display("FAIL rmb_stray_done got rv=%0d m=%0d wc=%0d st=%0d exp 0", res_valid, res_mean, win_count, start); end
      for (int k = 40; k < 44; k++) push(k);
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL rmb_relaunch_early got %0d exp 0", start); end
      step();
      checks++; if (start !== 1'b1) begin errors++; $display("FAIL rmb_relaunch got %0d exp 1", start); end
      step();
      index = 0; #1;
      checks++; if (value !== 32'd40) begin errors++; $display("FAIL rmb_idx0 got %0d exp 40", value); end
      index = 3; #1;
      checks++; if (value !== 32'd43) begin errors++; $display("FAIL rmb_idx3 got %0d exp 43", value); end
   endtask

   initial begin
      test_reset();
      test_fill_launch();
      test_result();
      test_backpressure();
      test_simultaneous();
      test_wrap();
      test_reset_mid_busy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/stat_window_feeder.md
Name: stat_window_feeder

Overview:
- Sample-side responder for the statistics engine's index/value read port.
- Accepts a stream of 32-bit time-series samples into a circular buffer.
- When a full window is present, launches the engine with si/ei/start and serves its index→value reads combinationally.
- Captures the returned mean/variance and slides the window by HOP samples.

Parameters:
- DEPTH, 16, buffer entries; power of 2, at least WIN+HOP.
- WIN, 8, samples per window; 1 ≤ WIN ≤ DEPTH.
- HOP, 8, samples retired per completed window; 1 ≤ HOP ≤ WIN.

Ports:
- Clk  in  1  clock.
- Rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  sample offered.
- in_data  in  32  sample value.
- in_ready  out  1  buffer can accept a sample.
- index  in  32  logical read index from the stats engine.
- value  out  32  sample at that logical index (combinational).
- si  out  32  window start index to the engine.
- ei  out  32  window end index to the engine (exclusive).
- start  out  1  one-cycle launch pulse to the engine.
- done  in  1  one-cycle completion pulse from the engine.
- mean_in  in  32  engine mean, valid with done.
- variance_in  in  32  engine variance, valid with done.
- res_valid  out  1  one-cycle result pulse.
- res_mean  out  32  captured mean.
- res_variance  out  32  captured variance.
- win_count  out  16  completed windows, wraps at 2^16.

Behaviour:
- Reset values: all outputs 0; wp=0, base=0, occ=0; state=FILL. Buffer contents are don't-care.
- Constants: si is always 0 and ei is always WIN. Both are driven continuously after reset.
- Write handshake:
  - in_ready = (occ < DEPTH).
  - A write occurs when in_valid && in_ready: mem[wp] <= in_data, wp <= wp+1 mod DEPTH, occ increments.
  - When in_ready is low, in_data is ignored and no sample is lost or counted.
- Read:
  - In BUSY with index < WIN: value = mem[(base+index) mod DEPTH]. Logical index 0 is the oldest sample in the window.
  - Otherwise value = 0.
  - The path is purely combinational; the engine samples value in the same cycle it presents index.
- FSM FILL:
  - If occ ≥ WIN (using the registered occ), go to LAUNCH.
  - Writes continue in this state.
- FSM LAUNCH:
  - start=1 for exactly this cycle; next state BUSY.
  - Window slots base..base+WIN-1 are frozen from this cycle onward.
- FSM BUSY:
  - start=0; wait for done.
  - Writes continue only into slots outside the window (guaranteed by occ ≤ DEPTH).
  - On done:
    - res_mean <= mean_in, res_variance <= variance_in, res_valid=1 next cycle for one cycle.
    - win_count increments.
    - base <= base+HOP mod DEPTH; occ decreases by HOP.
    - Next state FILL.
- Simultaneous accepted write and done: occ <= occ + 1 − HOP in that one cycle.
- A done in FILL or LAUNCH is ignored: no capture, no state change.
- Async reset at any time, including mid-BUSY: returns to the reset values immediately. The buffer is logically emptied and any engine transaction in flight is abandoned; a later done is ignored in FILL.
- Pointer arithmetic: log2(DEPTH) bits, wrapping naturally. occ is log2(DEPTH)+1 bits.

Decomposition:
- Shared package (stat_pkg): the FSM state encoding (FILL/LAUNCH/BUSY), the 32-bit data width constant, and the win_count width.
- One sub-module, stat_sample_ram:
  - DEPTH×32 storage.
  - Synchronous write port and asynchronous read port.
  - Takes the physical address; the top level computes (base+index) mod DEPTH.

Test Plan (DEPTH=8, WIN=4, HOP=4 unless stated):
- Fill and launch: push 2,4,6,8 → start pulses 2 cycles after the 4th write is accepted; si=0, ei=4; in BUSY, index 0→2 and index 3→8, index 4→0.
- Result capture: in BUSY, drive done with mean_in=5, variance_in=2 → next cycle res_valid=1, res_mean=5, res_variance=2, win_count=1; state returns to FILL with occ=0.
- Backpressure: launch a window, hold done low, push 4 more → occ=8, in_ready=0; the 9th offered sample is not stored; after done, in_ready=1 and a second start follows (occ=4).
- Wrap-around: run 3 windows of 1..4, 5..8, 9..12 → the third window reads index0=9 from physical slot 0; win_count=3.
- Simultaneous events: WIN=4, HOP=2 — a write accepted in the same cycle as done with occ=6 → occ=5, base advances by 2, index0 returns the old 3rd sample.
- Reset mid-BUSY: assert Rst during BUSY → start, res_valid and in_ready drop to 0 immediately; after release, occ=0, a stray done is ignored, and a fresh 4-sample fill relaunches correctly.
